cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Run/step sequencer that sits between the board buttons and the A09 CPU core on the TinyFPGA. It holds the CPU in reset at power-up, then gates CPU progress with a clock-enable: free-running at a divided rate (RUN), one instruction per press (STEP), or paused. It detects CPU halt and provides a heartbeat for a status LED. The CPU and this block share the same single clock.

Parameters:
DIV_WIDTH, 23, width of the rate divider counter.
DIV_COUNT, 7_999_999, divider terminal count; one tick every DIV_COUNT+1 cycles.
DEB_CYCLES, 16'd50_000, cycles a synchronized button must be stable before it is accepted.
RST_CYCLES, 8'd16, number of cycles Cpu_Reset is held after reset release or restart.
STEP_MAX, 16'd1024, watchdog limit in STEP, in enabled cycles.

Ports:
Clk  in  1  system clock, 16 MHz.
Reset  in  1  asynchronous, active-low.
Run_Btn  in  1  raw run/pause button, active-high, asynchronous.
Step_Btn  in  1  raw step button, active-high, asynchronous.
Cpu_Halt  in  1  CPU halt status.
Cpu_IR_Ld  in  1  CPU instruction-register load strobe; marks an instruction boundary.
Cpu_Clk_En  out  1  CPU advances only on cycles where this is 1.
Cpu_Reset  out  1  active-high synchronous reset to the CPU.
State  out  3  current FSM state encoding.
Step_Err  out  1  sticky flag: STEP watchdog expired.
Heartbeat  out  1  toggles on every divider wrap.

Behaviour:
- Reset values (Reset low): State=RESET_HOLD, Cpu_Clk_En=0, Cpu_Reset=1, Step_Err=0, Heartbeat=0, all counters 0.
- Buttons:
  - Each button passes through a 2-FF synchronizer, then a debouncer.
  - The debouncer emits a 1-cycle press pulse on an accepted 0→1 transition. Holding a button gives exactly one pulse.
  - Release must also be stable for DEB_CYCLES before another press is accepted.
- Divider:
  - Free-running, never reset by the FSM.
  - Wraps 0..DIV_COUNT. tick=1 on the wrap cycle; Heartbeat toggles on the same cycle.
- Encodings: RESET_HOLD=0, IDLE=1, RUN=2, STEP=3, HALTED=4.
- RESET_HOLD:
  - Cpu_Reset=1, Cpu_Clk_En=0. A hold counter counts to RST_CYCLES-1, then the FSM goes to IDLE.
  - Button pulses are discarded. Step_Err is cleared on entry.
- IDLE:
  - Cpu_Clk_En=0.
  - Priority: Cpu_Halt → HALTED; else run pulse → RUN; else step pulse → STEP.
- RUN:
  - Cpu_Clk_En=tick, registered so it is high in the cycle after the wrap.
  - Cpu_Halt → HALTED (enable forced 0 from that cycle). Run pulse → IDLE. Step pulse is ignored.
- STEP:
  - Cpu_Clk_En=1 every cycle in the state.
  - A first-cycle flag is set on entry. The first Cpu_IR_Ld=1 seen on a non-first enabled cycle ends the step: next state is IDLE and Cpu_Clk_En=0 in that next cycle.
  - The watchdog counts enabled cycles. Reaching STEP_MAX-1 → IDLE and sets Step_Err.
  - Cpu_Halt has priority over both endings → HALTED. Button pulses are ignored.
- HALTED:
  - Cpu_Clk_En=0.
  - Run pulse → RESET_HOLD (CPU restart). Step pulse is ignored.
  - Remains in HALTED even if Cpu_Halt drops.
- Run and step pulses in the same cycle: run wins, step is discarded.
- Reset asserted mid-operation returns immediately to RESET_HOLD with reset values. Cpu_Clk_En drops asynchronously.
- Counter comparisons use full parameter width. No counter wraps except the divider.

Decomposition:
- Shared package a09_ctrl_pkg: state encodings, and default DIV_COUNT/DEB_CYCLES/RST_CYCLES/STEP_MAX constants.
- Sub-module btn_debounce (synchronizer, stability counter, press pulse), instanced twice. Parameter DEB_CYCLES; ports Clk, Reset, Btn_In, Press.

Test Plan:
Use DIV_COUNT=3, DEB_CYCLES=2, RST_CYCLES=4, STEP_MAX=16.
1. Release Reset → Cpu_Reset=1 for exactly 4 cycles, then State=1 (IDLE), Cpu_Clk_En=0. Pressing Run during the hold has no effect.
2. Run press in IDLE → State=2; Cpu_Clk_En high 1 cycle in every 4; Heartbeat toggles every 4 cycles. Second Run press → State=1, enable stays 0.
3. Step press; CPU model pulses Cpu_IR_Ld on enabled cycles 1 and 4 → enable high for exactly 4 cycles, then State=1. The cycle-1 IR_Ld is ignored as the first cycle.
4. Step press with Cpu_IR_Ld held 0 → enable high for 16 cycles, then State=1 and Step_Err=1. Step_Err stays set through a later RUN.
5. Cpu_Halt=1 during RUN → State=4, enable 0 the same cycle. Step press ignored. Run press → RESET_HOLD with Cpu_Reset=1 for 4 cycles, then IDLE, Step_Err=0.
6. Run and Step pressed the same cycle → RUN. Button bounce shorter than 2 cycles → no pulse. Reset low mid-STEP → enable 0 immediately, State=0.

Source files
------------

// File: rtl/a09_ctrl_pkg.sv
// Shared definitions for the A09 run/step controller: FSM encodings and
// default timing constants for the 16 MHz board clock.
package a09_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    IDLE       = 3'd1,
    RUN        = 3'd2,
    STEP       = 3'd3,
    HALTED     = 3'd4
  } run_state_e;

  localparam int          DIV_WIDTH_D  = 23;
  localparam logic [22:0] DIV_COUNT_D  = 23'd7_999_999;
  localparam logic [15:0] DEB_CYCLES_D = 16'd50_000;
  localparam logic [7:0]  RST_CYCLES_D = 8'd16;
  localparam logic [15:0] STEP_MAX_D   = 16'd1024;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between the run controller and the A09 core.
interface cpu_run_ctrl_if;
  logic Cpu_Halt;
  logic Cpu_IR_Ld;
  logic Cpu_Clk_En;
  logic Cpu_Reset;

  modport master (input Cpu_Halt, input Cpu_IR_Ld, output Cpu_Clk_En, output Cpu_Reset);
  modport slave  (output Cpu_Halt, output Cpu_IR_Ld, input Cpu_Clk_En, input Cpu_Reset);
endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, one-cycle press pulse
// on an accepted rising level. Releases must be equally stable to be accepted.
module btn_debounce
  import a09_ctrl_pkg::*;
#(
  parameter logic [15:0] DEB_CYCLES = DEB_CYCLES_D
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Btn_In,
  output logic Press
);

  logic        sync1, sync2, level;
  logic [15:0] stab_cnt;

  // Synchronizer stages keep sampling the pin through reset, so a button
  // already held at reset release is seen (and discarded) during the hold.
  always_ff @(posedge Clk) begin
    sync1 <= Btn_In;
    sync2 <= sync1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      level    <= 1'b0;
      stab_cnt <= '0;
      Press    <= 1'b0;
    end else begin
      Press <= 1'b0;
      if (sync2 == level) begin
        stab_cnt <= '0;
      end else if (stab_cnt == DEB_CYCLES - 16'd1) begin
        level    <= sync2;
        stab_cnt <= '0;
        Press    <= sync2;
      end else begin
        stab_cnt <= stab_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer for the A09 core: reset hold, divided-rate RUN,
// single-instruction STEP with watchdog, halt capture and heartbeat.
module cpu_run_ctrl
  import a09_ctrl_pkg::*;
#(
  parameter int                   DIV_WIDTH  = DIV_WIDTH_D,
  parameter logic [DIV_WIDTH-1:0] DIV_COUNT  = DIV_COUNT_D,
  parameter logic [15:0]          DEB_CYCLES = DEB_CYCLES_D,
  parameter logic [7:0]           RST_CYCLES = RST_CYCLES_D,
  parameter logic [15:0]          STEP_MAX   = STEP_MAX_D
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Run_Btn,
  input  logic                  Step_Btn,
  cpu_run_ctrl_if.master        cpu,
  output logic [2:0]            State,
  output logic                  Step_Err,
  output logic                  Heartbeat
);

  logic                 run_p, step_p, tick;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [7:0]           hold_cnt;
  logic [15:0]          wd_cnt;
  logic                 step_first, clk_en, cpu_rst;
  run_state_e           state;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_deb (
    .Clk(Clk), .Reset(Reset), .Btn_In(Run_Btn), .Press(run_p));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .Clk(Clk), .Reset(Reset), .Btn_In(Step_Btn), .Press(step_p));

  assign tick = (div_cnt == DIV_COUNT);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_cnt   <= '0;
      Heartbeat <= 1'b0;
    end else if (tick) begin
      div_cnt   <= '0;
      Heartbeat <= ~Heartbeat;
    end else begin
      div_cnt   <= div_cnt + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= RESET_HOLD;
      clk_en     <= 1'b0;
      cpu_rst    <= 1'b1;
      Step_Err   <= 1'b0;
      hold_cnt   <= '0;
      wd_cnt     <= '0;
      step_first <= 1'b0;
    end else begin
      case (state)
        RESET_HOLD: begin
          clk_en  <= 1'b0;
          cpu_rst <= 1'b1;
          if (hold_cnt == RST_CYCLES - 8'd1) begin
            state    <= IDLE;
            cpu_rst  <= 1'b0;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        IDLE: begin
          clk_en <= 1'b0;
          if (cpu.Cpu_Halt)  state <= HALTED;
          else if (run_p)    state <= RUN;
          else if (step_p) begin
            state      <= STEP;
            clk_en     <= 1'b1;
            step_first <= 1'b1;
            wd_cnt     <= '0;
          end
        end
        RUN: begin
          if (cpu.Cpu_Halt) begin
            state  <= HALTED;
            clk_en <= 1'b0;
          end else if (run_p) begin
            state  <= IDLE;
            clk_en <= 1'b0;
          end else begin
            clk_en <= tick;
          end
        end
        STEP: begin
          // IR load on the entry cycle belongs to the instruction already in flight.
          if (cpu.Cpu_Halt) begin
            state  <= HALTED;
            clk_en <= 1'b0;
          end else if (cpu.Cpu_IR_Ld && !step_first) begin
            state  <= IDLE;
            clk_en <= 1'b0;
          end else if (wd_cnt == STEP_MAX - 16'd1) begin
            state    <= IDLE;
            clk_en   <= 1'b0;
            Step_Err <= 1'b1;
          end else begin
            wd_cnt     <= wd_cnt + 16'd1;
            step_first <= 1'b0;
          end
        end
        HALTED: begin
          clk_en <= 1'b0;
          if (run_p) begin
            state    <= RESET_HOLD;
            cpu_rst  <= 1'b1;
            hold_cnt <= '0;
            Step_Err <= 1'b0;
          end
        end
        default: begin
          state   <= RESET_HOLD;
          clk_en  <= 1'b0;
          cpu_rst <= 1'b1;
        end
      endcase
    end
  end

  assign cpu.Cpu_Clk_En = clk_en;
  assign cpu.Cpu_Reset  = cpu_rst;
  assign State          = state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with shortened timing constants.
module tb_cpu_run_ctrl;
  import a09_ctrl_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Run_Btn = 1'b0;
  logic       Step_Btn = 1'b0;
  logic [2:0] State;
  logic       Step_Err, Heartbeat;
  int         tests = 0;
  int         fails = 0;
  int         n_en, n_tg, guard;
  logic       hb_prev;

  cpu_run_ctrl_if cpu_bus();

  cpu_run_ctrl #(
    .DIV_WIDTH(23), .DIV_COUNT(23'd3), .DEB_CYCLES(16'd2),
    .RST_CYCLES(8'd4), .STEP_MAX(16'd16)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Run_Btn(Run_Btn), .Step_Btn(Step_Btn),
    .cpu(cpu_bus), .State(State), .Step_Err(Step_Err), .Heartbeat(Heartbeat)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press returns on the negedge right after the FSM has reacted to the pulse
  // (2 sync + 2 stability + 1 registered pulse edges).
  task automatic press(input logic r, input logic s);
    Run_Btn  = r;
    Step_Btn = s;
    repeat (5) @(negedge Clk);
  endtask

  task automatic release_btns();
    Run_Btn  = 1'b0;
    Step_Btn = 1'b0;
    repeat (6) @(negedge Clk);
  endtask

  initial begin
    cpu_bus.Cpu_Halt  = 1'b0;
    cpu_bus.Cpu_IR_Ld = 1'b0;

    // 1: reset values, 4-cycle hold, Run held across the hold is discarded
    Run_Btn = 1'b1;
    repeat (4) @(negedge Clk);
    chk("rst_state", 32'(State), 32'(RESET_HOLD));
    chk("rst_clk_en", 32'(cpu_bus.Cpu_Clk_En), 0);
    chk("rst_cpu_reset", 32'(cpu_bus.Cpu_Reset), 1);
    chk("rst_step_err", 32'(Step_Err), 0);
    chk("rst_heartbeat", 32'(Heartbeat), 0);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("hold_cpu_reset", 32'(cpu_bus.Cpu_Reset), 1);
      chk("hold_state", 32'(State), 32'(RESET_HOLD));
    end
    @(negedge Clk);
    chk("hold_done_state", 32'(State), 32'(IDLE));
    chk("hold_done_cpu_reset", 32'(cpu_bus.Cpu_Reset), 0);
    chk("idle_clk_en", 32'(cpu_bus.Cpu_Clk_En), 0);
    repeat (4) @(negedge Clk);
    chk("hold_press_discarded", 32'(State), 32'(IDLE));
    release_btns();

    // 2: RUN gives one enable per divider wrap, heartbeat toggles on wrap
    press(1'b1, 1'b0);
    chk("run_enter", 32'(State), 32'(RUN));
    hb_prev = Heartbeat;
    n_en = 0;
    n_tg = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      chk("run_en_on_wrap", 32'(cpu_bus.Cpu_Clk_En), 32'(Heartbeat ^ hb_prev));
      n_en += int'(cpu_bus.Cpu_Clk_En);
      n_tg += int'(Heartbeat ^ hb_prev);
      hb_prev = Heartbeat;
    end
    chk("run_en_count", 32'(n_en), 2);
    chk("hb_toggle_count", 32'(n_tg), 2);
    release_btns();
    press(1'b1, 1'b0);
    chk("run_pause", 32'(State), 32'(IDLE));
    n_en = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      n_en += int'(cpu_bus.Cpu_Clk_En);
    end
    chk("pause_en_count", 32'(n_en), 0);
    release_btns();

    // 3: step ends on the IR load of enabled cycle 4; cycle-1 IR load ignored
    press(1'b0, 1'b1);
    chk("step_c1_state", 32'(State), 32'(STEP));
    chk("step_c1_en", 32'(cpu_bus.Cpu_Clk_En), 1);
    cpu_bus.Cpu_IR_Ld = 1'b1;
    @(negedge Clk);
    cpu_bus.Cpu_IR_Ld = 1'b0;
    chk("step_c2_en", 32'(cpu_bus.Cpu_Clk_En), 1);
    chk("step_c2_state", 32'(State), 32'(STEP));
    @(negedge Clk);
    chk("step_c3_en", 32'(cpu_bus.Cpu_Clk_En), 1);
    @(negedge Clk);
    chk("step_c4_en", 32'(cpu_bus.Cpu_Clk_En), 1);
    cpu_bus.Cpu_IR_Ld = 1'b1;
    @(negedge Clk);
    cpu_bus.Cpu_IR_Ld = 1'b0;
    chk("step_end_en", 32'(cpu_bus.Cpu_Clk_En), 0);
    chk("step_end_state", 32'(State), 32'(IDLE));
    chk("step_no_err", 32'(Step_Err), 0);
    release_btns();

    // 4: step watchdog after 16 enabled cycles, Step_Err sticky into RUN
    press(1'b0, 1'b1);
    n_en = 0;
    guard = 0;
    while (cpu_bus.Cpu_Clk_En && guard < 40) begin
      n_en++;
      guard++;
      @(negedge Clk);
    end
    chk("wd_en_cycles", 32'(n_en), 16);
    chk("wd_state", 32'(State), 32'(IDLE));
    chk("wd_step_err", 32'(Step_Err), 1);
    release_btns();
    press(1'b1, 1'b0);
    chk("wd_run_state", 32'(State), 32'(RUN));
    chk("wd_err_sticky", 32'(Step_Err), 1);

    // 5: halt in RUN, step ignored, run restarts through the reset hold
    cpu_bus.Cpu_Halt = 1'b1;
    @(negedge Clk);
    chk("halt_state", 32'(State), 32'(HALTED));
    chk("halt_en", 32'(cpu_bus.Cpu_Clk_En), 0);
    release_btns();
    press(1'b0, 1'b1);
    chk("halt_step_ignored", 32'(State), 32'(HALTED));
    release_btns();
    cpu_bus.Cpu_Halt = 1'b0;
    @(negedge Clk);
    chk("halt_sticky", 32'(State), 32'(HALTED));
    press(1'b1, 1'b0);
    chk("restart_state", 32'(State), 32'(RESET_HOLD));
    chk("restart_err_clr", 32'(Step_Err), 0);
    for (int i = 0; i < 4; i++) begin
      chk("restart_cpu_reset", 32'(cpu_bus.Cpu_Reset), 1);
      @(negedge Clk);
    end
    chk("restart_idle", 32'(State), 32'(IDLE));
    chk("restart_cpu_reset_off", 32'(cpu_bus.Cpu_Reset), 0);
    chk("restart_step_err", 32'(Step_Err), 0);
    release_btns();

    // 6: simultaneous presses, short bounce, async reset mid-step
    press(1'b1, 1'b1);
    chk("both_run_wins", 32'(State), 32'(RUN));
    release_btns();
    press(1'b1, 1'b0);
    chk("both_back_idle", 32'(State), 32'(IDLE));
    release_btns();
    Step_Btn = 1'b1;
    @(negedge Clk);
    Step_Btn = 1'b0;
    repeat (8) @(negedge Clk);
    chk("bounce_no_pulse", 32'(State), 32'(IDLE));
    press(1'b0, 1'b1);
    chk("mid_step_state", 32'(State), 32'(STEP));
    @(negedge Clk);
    chk("mid_step_en", 32'(cpu_bus.Cpu_Clk_En), 1);
    #2 Reset = 1'b0;
    #1;
    chk("async_rst_en", 32'(cpu_bus.Cpu_Clk_En), 0);
    chk("async_rst_state", 32'(State), 32'(RESET_HOLD));
    chk("async_rst_cpu_reset", 32'(cpu_bus.Cpu_Reset), 1);
    Step_Btn = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
